// File: rtl/mc_maindec_pkg.sv
// mc_maindec_pkg
//   Shared definitions for the multicycle main controller: state encodings,
//   opcode constants, ALU-operation and mux-select codes, and the packed
//   control word passed from the state decoder to the top.
package mc_maindec_pkg;

  // State encodings (12 used out of a 4-bit register).
  localparam logic [3:0] S_FETCH   = 4'd0;
  localparam logic [3:0] S_DECODE  = 4'd1;
  localparam logic [3:0] S_MEMADR  = 4'd2;
  localparam logic [3:0] S_MEMRD   = 4'd3;
  localparam logic [3:0] S_MEMWB   = 4'd4;
  localparam logic [3:0] S_MEMWR   = 4'd5;
  localparam logic [3:0] S_RTYPEEX = 4'd6;
  localparam logic [3:0] S_RTYPEWB = 4'd7;
  localparam logic [3:0] S_BEQEX   = 4'd8;
  localparam logic [3:0] S_ADDIEX  = 4'd9;
  localparam logic [3:0] S_ADDIWB  = 4'd10;
  localparam logic [3:0] S_JEX     = 4'd11;

  // Opcodes.
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  // aluop codes seen by the ALU-control decoder.
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // ALU B-operand select.
  localparam logic [1:0] SRCB_B     = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  // Next-PC select.
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // Control word decoded purely from state. fetch_wr marks the FETCH
  // state, whose irwrite/pcwrite are only honoured once memrdy arrives;
  // decode marks the state in which an unknown opcode is flagged.
  typedef struct packed {
    logic       iord;
    logic       memwrite;
    logic       fetch_wr;
    logic       regdst;
    logic       memtoreg;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] aluop;
    logic [1:0] pcsrc;
    logic       pcwrite;
    logic       branch;
    logic       decode;
  } ctrl_t;

  function automatic logic op_known(input logic [5:0] op);
    return (op == OP_LW) || (op == OP_SW) || (op == OP_RTYPE) ||
           (op == OP_BEQ) || (op == OP_ADDI) || (op == OP_J);
  endfunction

endpackage

// File: rtl/mc_maindec_outdec.sv
// mc_outdec
//   Pure combinational state -> control-word decode for the multicycle
//   main controller. No input qualification happens here; memrdy/zero
//   gating is applied by the top.
//   Ports:
//     state  in  STATE_W  current (or reset-overridden) controller state
//     cw     out ctrl_t   control word for that state
module mc_outdec
  import mc_maindec_pkg::*;
#(
  parameter int STATE_W = 4
) (
  input  logic [STATE_W-1:0] state,
  output ctrl_t              cw
);

  always_comb begin
    cw = '0;
    case (state)
      S_FETCH: begin
        cw.alusrcb  = SRCB_FOUR;
        cw.aluop    = ALUOP_ADD;
        cw.fetch_wr = 1'b1;
      end
      S_DECODE: begin
        cw.alusrcb = SRCB_IMMSH;
        cw.aluop   = ALUOP_ADD;
        cw.decode  = 1'b1;
      end
      S_MEMADR: begin
        cw.alusrca = 1'b1;
        cw.alusrcb = SRCB_IMM;
        cw.aluop   = ALUOP_ADD;
      end
      S_MEMRD: begin
        cw.iord = 1'b1;
      end
      S_MEMWB: begin
        cw.memtoreg = 1'b1;
        cw.regwrite = 1'b1;
      end
      S_MEMWR: begin
        cw.iord     = 1'b1;
        cw.memwrite = 1'b1;
      end
      S_RTYPEEX: begin
        cw.alusrca = 1'b1;
        cw.alusrcb = SRCB_B;
        cw.aluop   = ALUOP_FUNCT;
      end
      S_RTYPEWB: begin
        cw.regdst   = 1'b1;
        cw.regwrite = 1'b1;
      end
      S_BEQEX: begin
        cw.alusrca = 1'b1;
        cw.alusrcb = SRCB_B;
        cw.aluop   = ALUOP_SUB;
        cw.pcsrc   = PCSRC_ALUOUT;
        cw.branch  = 1'b1;
      end
      S_ADDIEX: begin
        cw.alusrca = 1'b1;
        cw.alusrcb = SRCB_IMM;
        cw.aluop   = ALUOP_ADD;
      end
      S_ADDIWB: begin
        cw.regwrite = 1'b1;
      end
      S_JEX: begin
        cw.pcsrc   = PCSRC_JUMP;
        cw.pcwrite = 1'b1;
      end
      default: cw = '0;  // unused encodings: everything off
    endcase
  end

endmodule

// File: rtl/mc_maindec.sv
// mc_maindec
//   Multicycle main controller. Steps each instruction through
//   FETCH/DECODE/EXECUTE/MEM/WB states, stalling on memrdy in the memory
//   access states, and drives datapath enables plus aluop.
//   Ports:
//     clk, reset          clock and synchronous active-high reset
//     op[5:0]             opcode from the instruction register
//     zero                ALU zero flag (used in BEQEX only)
//     memrdy              memory access completed this cycle
//     iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca
//     alusrcb[1:0], aluop[1:0], pcsrc[1:0], pcen, illegal_op
module mc_maindec
  import mc_maindec_pkg::*;
#(
  parameter int STATE_W = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic       zero,
  input  logic       memrdy,
  output logic       iord,
  output logic       memwrite,
  output logic       irwrite,
  output logic       regdst,
  output logic       memtoreg,
  output logic       regwrite,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] aluop,
  output logic [1:0] pcsrc,
  output logic       pcen,
  output logic       illegal_op
);

  logic [STATE_W-1:0] state_reg;
  logic [STATE_W-1:0] state_next;
  logic [STATE_W-1:0] state_dec;
  logic               run;
  ctrl_t              cw;

  always_ff @(posedge clk) begin
    if (reset) state_reg <= S_FETCH;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = S_FETCH;
    case (state_reg)
      S_FETCH:   state_next = memrdy ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: state_next = S_MEMADR;
          OP_RTYPE:     state_next = S_RTYPEEX;
          OP_BEQ:       state_next = S_BEQEX;
          OP_ADDI:      state_next = S_ADDIEX;
          OP_J:         state_next = S_JEX;
          default:      state_next = S_FETCH;
        endcase
      end
      // op is still held by the instruction register here
      S_MEMADR:  state_next = (op == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:   state_next = memrdy ? S_MEMWB : S_MEMRD;
      S_MEMWB:   state_next = S_FETCH;
      S_MEMWR:   state_next = memrdy ? S_FETCH : S_MEMWR;
      S_RTYPEEX: state_next = S_RTYPEWB;
      S_RTYPEWB: state_next = S_FETCH;
      S_BEQEX:   state_next = S_FETCH;
      S_ADDIEX:  state_next = S_ADDIWB;
      S_ADDIWB:  state_next = S_FETCH;
      S_JEX:     state_next = S_FETCH;
      default:   state_next = S_FETCH;
    endcase
  end

  // During reset the muxes must already show FETCH values even though the
  // register has not yet been cleared, so decode FETCH directly.
  assign state_dec = reset ? S_FETCH : state_reg;
  assign run       = ~reset;

  mc_outdec #(.STATE_W(STATE_W)) u_outdec (
    .state (state_dec),
    .cw    (cw)
  );

  assign iord       = cw.iord;
  assign regdst     = cw.regdst;
  assign memtoreg   = cw.memtoreg;
  assign alusrca    = cw.alusrca;
  assign alusrcb    = cw.alusrcb;
  assign aluop      = cw.aluop;
  assign pcsrc      = cw.pcsrc;
  assign memwrite   = run & cw.memwrite;
  assign regwrite   = run & cw.regwrite;
  assign irwrite    = run & cw.fetch_wr & memrdy;
  assign pcen       = run & ((cw.fetch_wr & memrdy) | cw.pcwrite | (cw.branch & zero));
  assign illegal_op = run & cw.decode & ~op_known(op);

endmodule

// File: tb/tb_mc_maindec.sv
// tb_mc_maindec
//   Randomized scoreboard bench. The stimulus process expands each
//   instruction into its phase sequence, drives per-cycle inputs and pushes
//   the expected control outputs; a negedge monitor pops and compares.
module tb_mc_maindec;

  logic       clk = 1'b1;
  logic       reset = 1'b1;
  logic [5:0] op = 6'd0;
  logic       zero = 1'b0;
  logic       memrdy = 1'b0;
  logic       iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca;
  logic [1:0] alusrcb, aluop, pcsrc;
  logic       pcen, illegal_op;

  always #5 clk = ~clk;

  mc_maindec dut (
    .clk        (clk),
    .reset      (reset),
    .op         (op),
    .zero       (zero),
    .memrdy     (memrdy),
    .iord       (iord),
    .memwrite   (memwrite),
    .irwrite    (irwrite),
    .regdst     (regdst),
    .memtoreg   (memtoreg),
    .regwrite   (regwrite),
    .alusrca    (alusrca),
    .alusrcb    (alusrcb),
    .aluop      (aluop),
    .pcsrc      (pcsrc),
    .pcen       (pcen),
    .illegal_op (illegal_op)
  );

  typedef struct {
    logic [14:0] v;
    string       ph;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  function automatic logic rb();
    return logic'($urandom_range(1, 0));
  endfunction

  function automatic logic is_legal(input logic [5:0] o);
    return o == 6'b100011 || o == 6'b101011 || o == 6'b000000 ||
           o == 6'b000100 || o == 6'b001000 || o == 6'b000010;
  endfunction

  // Expected outputs for one cycle, straight from the per-phase output table.
  // Packing: iord memwrite irwrite regdst memtoreg regwrite alusrca
  //          alusrcb[2] aluop[2] pcsrc[2] pcen illegal_op
  function automatic logic [14:0] model(input string ph, input logic rdy,
                                        input logic z, input logic rst,
                                        input logic [5:0] o);
    logic e_iord, e_mw, e_ir, e_rd, e_m2r, e_rw, e_sa, e_pcen, e_ill;
    logic [1:0] e_sb, e_aop, e_pcs;
    {e_iord, e_mw, e_ir, e_rd, e_m2r, e_rw, e_sa, e_pcen, e_ill} = '0;
    e_sb = 2'b00; e_aop = 2'b00; e_pcs = 2'b00;
    if (rst) begin
      e_sb = 2'b01;
    end else if (ph == "FETCH") begin
      e_sb = 2'b01; e_ir = rdy; e_pcen = rdy;
    end else if (ph == "DECODE") begin
      e_sb = 2'b11; e_ill = !is_legal(o);
    end else if (ph == "MEMADR" || ph == "ADDIEX") begin
      e_sa = 1'b1; e_sb = 2'b10;
    end else if (ph == "MEMRD") begin
      e_iord = 1'b1;
    end else if (ph == "MEMWB") begin
      e_m2r = 1'b1; e_rw = 1'b1;
    end else if (ph == "MEMWR") begin
      e_iord = 1'b1; e_mw = 1'b1;
    end else if (ph == "RTYPEEX") begin
      e_sa = 1'b1; e_aop = 2'b10;
    end else if (ph == "RTYPEWB") begin
      e_rd = 1'b1; e_rw = 1'b1;
    end else if (ph == "BEQEX") begin
      e_sa = 1'b1; e_aop = 2'b01; e_pcs = 2'b01; e_pcen = z;
    end else if (ph == "ADDIWB") begin
      e_rw = 1'b1;
    end else if (ph == "JEX") begin
      e_pcs = 2'b10; e_pcen = 1'b1;
    end
    return {e_iord, e_mw, e_ir, e_rd, e_m2r, e_rw, e_sa, e_sb, e_aop, e_pcs, e_pcen, e_ill};
  endfunction

  // One clock cycle of stimulus: drive inputs, record expectation, advance.
  task automatic cyc(input string ph, input logic rdy, input logic z, input logic rst);
    exp_t e;
    memrdy = rdy;
    zero   = z;
    reset  = rst;
    e.v  = model(ph, rdy, z, rst, op);
    e.ph = ph;
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // Execute phases after DECODE, by instruction class.
  task automatic exec_phase(input string ph, input logic z, input int mw);
    if (ph == "MEMRD" || ph == "MEMWR") begin
      for (int i = 0; i < mw; i++) cyc(ph, 1'b0, rb(), 1'b0);
      cyc(ph, 1'b1, rb(), 1'b0);
    end else if (ph == "BEQEX") begin
      cyc(ph, rb(), z, 1'b0);
    end else begin
      cyc(ph, rb(), rb(), 1'b0);
    end
  endtask

  task automatic run_instr(input logic [5:0] o, input logic z, input int fw, input int mw);
    op = o;
    for (int i = 0; i < fw; i++) cyc("FETCH", 1'b0, rb(), 1'b0);
    cyc("FETCH", 1'b1, rb(), 1'b0);
    cyc("DECODE", rb(), rb(), 1'b0);
    case (o)
      6'b100011: begin
        exec_phase("MEMADR", z, mw); exec_phase("MEMRD", z, mw); exec_phase("MEMWB", z, mw);
      end
      6'b101011: begin
        exec_phase("MEMADR", z, mw); exec_phase("MEMWR", z, mw);
      end
      6'b000000: begin
        exec_phase("RTYPEEX", z, mw); exec_phase("RTYPEWB", z, mw);
      end
      6'b000100: exec_phase("BEQEX", z, mw);
      6'b001000: begin
        exec_phase("ADDIEX", z, mw); exec_phase("ADDIWB", z, mw);
      end
      6'b000010: exec_phase("JEX", z, mw);
      default: ;  // unknown opcode returns straight to FETCH
    endcase
  endtask

  function automatic logic [5:0] pick_op(input int k);
    logic [5:0] o;
    case (k)
      0: o = 6'b100011;
      1: o = 6'b101011;
      2: o = 6'b000000;
      3: o = 6'b000100;
      4: o = 6'b001000;
      5: o = 6'b000010;
      default: begin
        o = 6'($urandom_range(63, 0));
        while (is_legal(o)) o = 6'($urandom_range(63, 0));
      end
    endcase
    return o;
  endfunction

  // Monitor: one comparison per clock whenever an expectation is pending.
  exp_t        m_e;
  logic [14:0] m_got;
  always @(negedge clk) begin
    if (q.size() > 0) begin
      m_e   = q.pop_front();
      m_got = {iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca,
               alusrcb, aluop, pcsrc, pcen, illegal_op};
      n_tests++;
      if (m_got !== m_e.v) begin
        n_fail++;
        $display("FAIL %s: got %b expected %b (iord mw ir rd m2r rw sa sb aop pcs pcen ill)",
                 m_e.ph, m_got, m_e.v);
      end else begin
        $display("[TB] %s ok %b", m_e.ph, m_got);
      end
    end
  end

  initial begin
    #1;
    // Two reset cycles.
    cyc("RESET", 1'b0, 1'b0, 1'b1);
    cyc("RESET", 1'b1, 1'b1, 1'b1);

    // Directed cases.
    run_instr(6'b000000, 1'b0, 0, 0);   // R-type, 4 cycles
    run_instr(6'b100011, 1'b0, 0, 3);   // lw, memrdy low 3 cycles in MEMRD
    run_instr(6'b101011, 1'b0, 0, 2);   // sw, memrdy low 2 cycles in MEMWR
    run_instr(6'b000100, 1'b1, 0, 0);   // beq taken
    run_instr(6'b000100, 1'b0, 0, 0);   // beq not taken
    run_instr(6'b111111, 1'b0, 0, 0);   // illegal
    run_instr(6'b000010, 1'b0, 0, 0);   // j
    run_instr(6'b001000, 1'b0, 0, 0);   // addi

    // Reset in the middle of a stalled store: no write after reset.
    op = 6'b101011;
    cyc("FETCH", 1'b1, 1'b0, 1'b0);
    cyc("DECODE", 1'b0, 1'b0, 1'b0);
    cyc("MEMADR", 1'b0, 1'b0, 1'b0);
    cyc("MEMWR", 1'b0, 1'b0, 1'b0);
    cyc("RESET", 1'b0, 1'b0, 1'b1);
    // Restart with memrdy low in FETCH: no irwrite/pcen until it rises.
    run_instr(6'b000000, 1'b0, 2, 0);

    // Randomized instruction stream.
    for (int n = 0; n < 200; n++) begin
      run_instr(pick_op(int'($urandom_range(6, 0))), rb(),
                int'($urandom_range(2, 0)), int'($urandom_range(3, 0)));
    end

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
    #1;
    if (q.size() > 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
